// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizes: architectural/physical tag widths, free-list geometry.
// Used by the allocator, the rename table and the ROB.
package rename_pkg;

  localparam int unsigned ARCH_REGS    = 32;
  localparam int unsigned PHYS_REGS    = 48;
  localparam int unsigned RENAME_PORTS = 2;
  localparam int unsigned COMMIT_PORTS = 2;
  localparam int unsigned MAX_LANES    = (RENAME_PORTS > COMMIT_PORTS) ? RENAME_PORTS : COMMIT_PORTS;

  localparam int unsigned ARCH_IDX_W = 5;
  localparam int unsigned PHYS_IDX_W = 6;

  localparam int unsigned FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int unsigned FL_IDX_W = $clog2(FL_DEPTH);
  localparam int unsigned FL_PTR_W = FL_IDX_W + 1;

  typedef logic [ARCH_IDX_W-1:0] arch_idx_t;
  typedef logic [PHYS_IDX_W-1:0] phys_idx_t;
  typedef logic [FL_IDX_W-1:0]   fl_idx_t;
  typedef logic [FL_PTR_W-1:0]   fl_ptr_t;

  // Number of set lanes, sized as a free-list pointer so it adds straight onto head/tail.
  function automatic fl_ptr_t popcount_lanes(input logic [MAX_LANES-1:0] v);
    fl_ptr_t cnt;
    cnt = '0;
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      cnt = cnt + fl_ptr_t'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/freelist_ram.sv
// Free-list storage: FL_DEPTH physical tags, async multi-port read, sync multi-port write.
// Reset loads the tags that are unmapped out of reset (ARCH_REGS upward).
module freelist_ram
  import rename_pkg::*;
#(
  parameter int unsigned RD_PORTS  = RENAME_PORTS,
  parameter int unsigned WR_PORTS  = COMMIT_PORTS,
  parameter int unsigned INIT_BASE = ARCH_REGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  fl_idx_t   [RD_PORTS-1:0] rd_addr,
  output phys_idx_t [RD_PORTS-1:0] rd_data,
  input  logic      [WR_PORTS-1:0] wr_en,
  input  fl_idx_t   [WR_PORTS-1:0] wr_addr,
  input  phys_idx_t [WR_PORTS-1:0] wr_data
);

  phys_idx_t mem [FL_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(FL_DEPTH); k++) begin
        mem[k] <= PHYS_IDX_W'(int'(INIT_BASE) + k);
      end
    end else begin
      for (int w = 0; w < int'(WR_PORTS); w++) begin
        if (wr_en[w]) mem[wr_addr[w]] <= wr_data[w];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < int'(RD_PORTS); r++) begin
      rd_data[r] = mem[rd_addr[r]];
    end
  end

endmodule

// File: rtl/phys_reg_alloc_ctrl.sv
// Rename-stage physical tag allocator: all-or-nothing group grants from a circular free list,
// commit-time reclaim of superseded tags, and flush rewind of the speculative head.
module phys_reg_alloc_ctrl
  import rename_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic      [RENAME_PORTS-1:0] alloc_req,
  input  arch_idx_t [RENAME_PORTS-1:0] alloc_arch_rd,
  output logic                         alloc_gnt,
  output logic      [RENAME_PORTS-1:0] rename_en,
  output phys_idx_t [RENAME_PORTS-1:0] new_phys_rd,
  input  logic      [COMMIT_PORTS-1:0] commit_en,
  input  logic      [COMMIT_PORTS-1:0] commit_has_dest,
  input  phys_idx_t [COMMIT_PORTS-1:0] commit_old_phys,
  input  logic                         flush_pipeline,
  output logic      [FL_PTR_W-1:0]     free_count
);

  fl_ptr_t spec_head;
  fl_ptr_t commit_head;
  fl_ptr_t tail;

  logic [RENAME_PORTS-1:0] need_vec;
  logic [COMMIT_PORTS-1:0] free_vec;
  fl_ptr_t                 need;
  fl_ptr_t                 nfree;
  fl_ptr_t                 rd_ofs;
  fl_ptr_t                 wr_ofs;
  fl_idx_t [RENAME_PORTS-1:0] rd_addr;
  fl_idx_t [COMMIT_PORTS-1:0] wr_addr;

  // Grant decision and compacted read/write slot selection.
  always_comb begin
    need_vec = '0;
    free_vec = '0;
    rd_addr  = '0;
    wr_addr  = '0;
    rd_ofs   = '0;
    wr_ofs   = '0;

    for (int i = 0; i < int'(RENAME_PORTS); i++) begin
      need_vec[i] = alloc_req[i] & (alloc_arch_rd[i] != '0);
    end
    for (int i = 0; i < int'(COMMIT_PORTS); i++) begin
      free_vec[i] = commit_en[i] & commit_has_dest[i] & (commit_old_phys[i] != '0);
    end

    need       = popcount_lanes(MAX_LANES'(need_vec));
    nfree      = popcount_lanes(MAX_LANES'(free_vec));
    free_count = tail - spec_head;
    alloc_gnt  = (|alloc_req) & ~flush_pipeline & ~reset & (need <= free_count);
    rename_en  = need_vec & {RENAME_PORTS{alloc_gnt}};

    for (int i = 0; i < int'(RENAME_PORTS); i++) begin
      rd_addr[i] = fl_idx_t'(spec_head + rd_ofs);
      rd_ofs     = rd_ofs + fl_ptr_t'(need_vec[i]);
    end
    for (int i = 0; i < int'(COMMIT_PORTS); i++) begin
      wr_addr[i] = fl_idx_t'(tail + wr_ofs);
      wr_ofs     = wr_ofs + fl_ptr_t'(free_vec[i]);
    end
  end

  // Pointers: tail and commit_head move together, so tail - commit_head stays FL_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= FL_PTR_W'(FL_DEPTH);
    end else begin
      tail        <= tail + nfree;
      commit_head <= commit_head + nfree;
      if (flush_pipeline) begin
        spec_head <= commit_head + nfree;
      end else if (alloc_gnt) begin
        spec_head <= spec_head + need;
      end
    end
  end

  freelist_ram u_freelist_ram (
    .clk     (clk),
    .reset   (reset),
    .rd_addr (rd_addr),
    .rd_data (new_phys_rd),
    .wr_en   (free_vec),
    .wr_addr (wr_addr),
    .wr_data (commit_old_phys)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (free_count <= FL_PTR_W'(FL_DEPTH));
      assert (fl_ptr_t'(tail - commit_head) == FL_PTR_W'(FL_DEPTH));
      for (int i = 0; i < int'(COMMIT_PORTS); i++) begin
        if (commit_en[i] & commit_has_dest[i]) assert (commit_old_phys[i] != '0);
      end
    end
  end

endmodule
